// File: rtl/font_mem_arbiter.sv
// Font memory arbiter: the display has absolute priority and the host is served in blanking gaps.
// Define FONT_MEM_ARBITER_STATS_EN to add the saturating host stall counter port host_stall_cnt_o.
module font_mem_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  disp_req_i,
    input  logic [ADDR_WIDTH-1:0] disp_addr_i,
    output logic                  disp_valid_o,
    output logic [0:DATA_WIDTH-1] disp_data_o,
    input  logic                  host_req_i,
    input  logic [ADDR_WIDTH-1:0] host_addr_i,
    output logic                  host_gnt_o,
    output logic                  host_valid_o,
    output logic [0:DATA_WIDTH-1] host_data_o,
`ifdef FONT_MEM_ARBITER_STATS_EN
    output logic [15:0]           host_stall_cnt_o,
`endif
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [0:DATA_WIDTH-1] mem_data_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD1  = 2'd1;
    localparam logic [1:0] ST_RD2  = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_DISP = 2'd1;
    localparam logic [1:0] OWN_HOST = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0]            owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  disp_valid_q, disp_valid_d;
    logic [0:DATA_WIDTH-1] disp_data_q, disp_data_d;
    logic                  host_valid_q, host_valid_d;
    logic [0:DATA_WIDTH-1] host_data_q, host_data_d;
    logic                  host_gnt;

    // The owner tag follows each memory cycle by one clock, which is exactly when its data returns.
    always_comb begin
        host_gnt   = rstn_i && (state_q == ST_IDLE) && host_req_i && !disp_req_i;
        mem_addr_d = mem_addr_q;
        owner_d    = OWN_NONE;
        if (disp_req_i) begin
            mem_addr_d = disp_addr_i;
            owner_d    = OWN_DISP;
        end else if (host_gnt) begin
            mem_addr_d = host_addr_i;
            owner_d    = OWN_HOST;
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (host_gnt) state_d = ST_RD1;
            ST_RD1:  state_d = ST_RD2;
            ST_RD2:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        disp_valid_d = (owner_q == OWN_DISP);
        disp_data_d  = disp_data_q;
        host_valid_d = (owner_q == OWN_HOST);
        host_data_d  = host_data_q;
        if (owner_q == OWN_DISP) begin
            disp_data_d = mem_data_i;
        end
        if (owner_q == OWN_HOST) begin
            host_data_d = mem_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            mem_addr_q   <= '0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            host_valid_q <= 1'b0;
            host_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            mem_addr_q   <= mem_addr_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            host_valid_q <= host_valid_d;
            host_data_q  <= host_data_d;
        end
    end

`ifdef FONT_MEM_ARBITER_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Counts IDLE cycles in which a pending host request loses to the display.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_IDLE) && host_req_i && disp_req_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign host_stall_cnt_o = stall_cnt_q;
`endif

    assign mem_addr_o   = mem_addr_d;
    assign host_gnt_o   = host_gnt;
    assign disp_valid_o = disp_valid_q;
    assign disp_data_o  = disp_data_q;
    assign host_valid_o = host_valid_q;
    assign host_data_o  = host_data_q;

endmodule

// File: doc/font_mem_arbiter.md
FONT_MEM_ARBITER -- requirements
Module: font_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11: font memory address width, {char[6:0], row[3:0]}.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: pixels per font row.
REQ-003 SHALL have port clk_i  input  1: 25 MHz clock; the block has one clock domain.
REQ-004 SHALL have port rstn_i  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port disp_req_i  input  1: display pipeline read request, one cycle per fetch.
REQ-006 SHALL have port disp_addr_i  input  ADDR_WIDTH: display fetch address.
REQ-007 SHALL have port disp_valid_o  output  1: display read data valid, one-cycle pulse.
REQ-008 SHALL have port disp_data_o  output  [0:DATA_WIDTH-1]: display read data.
REQ-009 SHALL have port host_req_i  input  1: host read request, level, held until host_gnt_o.
REQ-010 SHALL have port host_addr_i  input  ADDR_WIDTH: host address, stable while host_req_i is high.
REQ-011 SHALL have port host_gnt_o  output  1: host request accepted, one-cycle pulse.
REQ-012 SHALL have port host_valid_o  output  1: host read data valid, one-cycle pulse.
REQ-013 SHALL have port host_data_o  output  [0:DATA_WIDTH-1]: host read data.
REQ-014 SHALL have port mem_addr_o  output  ADDR_WIDTH: address to the font memory, which has a registered read with 1-cycle latency.
REQ-015 SHALL have port mem_data_i  input  [0:DATA_WIDTH-1]: font memory read data.

Function
REQ-016 SHALL give the display absolute priority: when disp_req_i=1, mem_addr_o=disp_addr_i in the same cycle (combinational mux); a display request is never stalled or dropped.
REQ-017 SHALL register disp_data_o<=mem_data_i and pulse disp_valid_o exactly 2 cycles after the cycle disp_req_i was high.
REQ-018 SHALL support display requests on every cycle, giving one valid pulse per request in order.
REQ-019 SHALL implement host FSM IDLE -> RD1 -> RD2 -> IDLE.
- IDLE: if host_req_i=1 and disp_req_i=0, then mem_addr_o=host_addr_i, host_gnt_o=1 that cycle, go to RD1.
- IDLE, request blocked by the display: stay in IDLE, no grant.
REQ-020 SHALL, in RD1, ignore host_req_i and grant nothing; the host memory data arrives this cycle and the next state is RD2.
REQ-021 SHALL, in RD2, present host_data_o (registered capture of mem_data_i from RD1) with host_valid_o=1, then return to IDLE.
REQ-022 SHALL tag each memory cycle with its owner (display/host/none) in a 1-cycle register so that data is routed only to that owner; a display read during RD1/RD2 is still served.
REQ-023 SHALL hold mem_addr_o at its last driven value when neither side issues a request.
REQ-024 SHALL hold host_data_o and disp_data_o stable between valid pulses.
REQ-025 SHALL grant host_req_i asserted in the RD2 cycle at the earliest in the following IDLE cycle, so host throughput is at most one read per 3 cycles.
REQ-026 SHALL continue to withhold host grants while disp_req_i stays continuously high (active video); the host is served during blanking gaps.

Reset
REQ-027 SHALL, when rstn_i=0 at a clock edge:
- FSM goes to IDLE; owner tags cleared.
- mem_addr_o, disp_data_o and host_data_o reset to 0.
- disp_valid_o, host_valid_o and host_gnt_o reset to 0.
REQ-028 SHALL discard any read in flight when reset occurs, producing no valid pulse for it after reset deasserts.

Configuration
REQ-029 SHALL, with macro FONT_MEM_ARBITER_STATS_EN defined, add port host_stall_cnt_o output 16: a saturating count (holds at 0xFFFF) of cycles in IDLE with host_req_i=1 and disp_req_i=1, reset to 0 by rstn_i.
REQ-030 SHALL, without FONT_MEM_ARBITER_STATS_EN, omit the port and the counter, with all other behaviour identical.

Verification
REQ-031 SHALL test: disp_req_i=1, disp_addr_i=0x410 for 1 cycle -> mem_addr_o=0x410 same cycle; disp_valid_o=1 with disp_data_o=mem[0x410] 2 cycles later.
REQ-032 SHALL test: host_req_i=1, host_addr_i=0x7F3, display idle -> host_gnt_o same cycle; host_valid_o with mem[0x7F3] 2 cycles later; FSM back in IDLE.
REQ-033 SHALL test: host_req_i held and disp_req_i high for 10 cycles -> no grant for 10 cycles, grant on cycle 11; with STATS_EN, host_stall_cnt_o=10.
REQ-034 SHALL test: host granted, then disp_req_i high in RD1 and RD2 -> both valid streams correct, with no data crossed between owners.
REQ-035 SHALL test: rstn_i=0 in RD1 -> no host_valid_o pulse; all outputs 0 the next cycle.
REQ-036 SHALL test: with STATS_EN, 70000 blocked cycles -> host_stall_cnt_o saturates at 0xFFFF.
